aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: ACK_WAIT, default 4, maximum cycles from trig pulse to blk_busy rise before a protocol error.
REQ-002 Parameter: TIMEOUT, default 1023, maximum cycles of blk_busy high per round (used only with ROUND_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 in_valid  in  1 / in_ready  out  1 / in_text  in  128 / in_key  in  128: job input handshake; transfer when in_valid && in_ready.
REQ-006 blk_trig  out  1 / blk_first  out  1 / blk_end  out  1 / blk_count  out  4: drive the round block's sample trigger, first-round enable, end-round enable and round count.
REQ-007 blk_data_in  out  128 / blk_key  out  128: round-block state and key inputs.
REQ-008 blk_data_out  in  128 / blk_busy  in  1: round-block result and busy flag.
REQ-009 out_valid  out  1 / out_ready  in  1 / out_text  out  128: result handshake; transfer when out_valid && out_ready.
REQ-010 err  out  1: sticky error flag.

Function
REQ-011 States: IDLE, WHITEN, TRIG, WAIT_ACK, WAIT_DONE, NEXT, OUT.
REQ-012 IDLE: in_ready=1; on transfer, latch in_text and in_key, clear err, go to WHITEN; in_ready=0 in every other state.
REQ-013 WHITEN, one cycle: state_reg <= text ^ key; round <= 1; go to TRIG.
REQ-014 TRIG, one cycle: blk_trig=1; go to WAIT_ACK; blk_trig=0 in every other state.
REQ-015 WAIT_ACK: on blk_busy=1 go to WAIT_DONE; after ACK_WAIT cycles without it, set err and return to IDLE with no out_valid.
REQ-016 WAIT_DONE: on blk_busy 1->0 (falling edge versus the registered previous value) go to NEXT.
REQ-017 NEXT, one cycle: state_reg <= blk_data_out; if round==10 go to OUT, else round+1 and go to TRIG.
REQ-018 blk_count=round (1..10) and blk_data_in=state_reg, held stable from TRIG through WAIT_DONE.
REQ-019 blk_key=latched key; the round block's internal key schedule advances the key.
REQ-020 blk_first=1 iff round==1 in TRIG, WAIT_ACK or WAIT_DONE; blk_end=1 iff round==10 in those states.
REQ-021 OUT: out_valid=1 and out_text=state_reg, both held until out_ready; on transfer go to IDLE.
REQ-022 Back-to-back: a new job may be accepted on the cycle after the OUT transfer.
REQ-023 Latency for an ideal block (ack after 1 cycle, busy high B cycles), input transfer to out_valid = 2 + 10*(B+3) cycles.
REQ-024 in_valid while not in IDLE is ignored; input data is sampled only at the transfer.
REQ-025 blk_busy already high in IDLE is ignored; no trigger is issued.

Reset
REQ-026 Reset returns the block to IDLE from any state, discarding any job in flight.
REQ-027 Reset values: in_ready=1; blk_trig, blk_first, blk_end, out_valid and err=0; blk_count=0.
REQ-028 Reset values: blk_data_in, blk_key and out_text=0; round=0.
REQ-029 Reset mid-job: the round block is not triggered again until a new in_valid transfer.

Configuration
REQ-030 Macro ROUND_TIMEOUT_EN defined: in WAIT_DONE, count cycles with blk_busy high; on reaching TIMEOUT, set err and return to IDLE with no out_valid.
REQ-031 Macro ROUND_TIMEOUT_EN undefined: WAIT_DONE waits indefinitely; no timeout counter is present.

Verification
REQ-032 FIPS-197 vector: key 000102..0f, text 00112233..ff, behavioural round-block model -> out_text 69c4e0d86a7b0430d8cdb78070b4c55a; blk_trig pulsed exactly 10 times; blk_first high only in round 1; blk_end high only in round 10.
REQ-033 out_ready low for 20 cycles after out_valid rises -> out_valid and out_text stable throughout; in_ready=0 until the OUT transfer.
REQ-034 Model never raises blk_busy -> err=1 ACK_WAIT cycles after the trig pulse; state returns to IDLE; out_valid stays 0.
REQ-035 Reset asserted during round 5 -> next cycle all outputs at reset values; next job (same vector) yields the correct result.
REQ-036 With ROUND_TIMEOUT_EN, TIMEOUT=15, model holds blk_busy high indefinitely -> err=1 after 15 busy cycles; IDLE; in_ready=1.
REQ-037 Two jobs back-to-back, in_valid held high -> second job accepted the cycle after the first OUT transfer; both results correct.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if
//   Groups every non-clock/reset signal of the AES round controller.
//   slave  : controller view (accepts jobs, drives the round block, returns results)
//   master : environment view (job source, round block, result sink)
//   Job input   : in_valid, in_ready, in_text[127:0], in_key[127:0]
//   Round block : blk_trig, blk_first, blk_end, blk_count[3:0],
//                 blk_data_in[127:0], blk_key[127:0], blk_data_out[127:0], blk_busy
//   Result      : out_valid, out_ready, out_text[127:0]
//   Status      : err (sticky, cleared when a new job is accepted)
interface aes_round_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_text;
   logic [127:0] in_key;
   logic         blk_trig;
   logic         blk_first;
   logic         blk_end;
   logic [3:0]   blk_count;
   logic [127:0] blk_data_in;
   logic [127:0] blk_key;
   logic [127:0] blk_data_out;
   logic         blk_busy;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_text;
   logic         err;

   modport slave (
      input  in_valid, in_text, in_key, blk_data_out, blk_busy, out_ready,
      output in_ready, blk_trig, blk_first, blk_end, blk_count,
             blk_data_in, blk_key, out_valid, out_text, err
   );

   modport master (
      output in_valid, in_text, in_key, blk_data_out, blk_busy, out_ready,
      input  in_ready, blk_trig, blk_first, blk_end, blk_count,
             blk_data_in, blk_key, out_valid, out_text, err
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
//   Sequences ten AES-128 rounds through an external round block: latches a
//   job, applies the initial key whitening, then for each round pulses the
//   block trigger, waits for busy to rise (bounded by ACK_WAIT) and fall, and
//   captures the round result. The final state is presented on out_text.
//   Ports: clk, reset (synchronous, active-high), bus (aes_round_ctrl_if.slave).
//   Parameters: ACK_WAIT (cycles allowed for busy to rise after the trigger),
//               TIMEOUT  (busy-high cycles allowed per round, timeout build only).
//   Optional feature macro: ROUND_TIMEOUT_EN enables the per-round busy timeout.
//
//   state       | meaning
//   S_IDLE      | ready for a job; in_ready=1
//   S_WHITEN    | state <= text ^ key, round <= 1
//   S_TRIG      | one-cycle trigger pulse to the round block
//   S_WAIT_ACK  | wait for busy to rise, error after ACK_WAIT cycles
//   S_WAIT_DONE | wait for busy falling edge
//   S_NEXT      | capture round result, advance round or finish
//   S_OUT       | hold result until out_ready
module aes_round_ctrl #(
   parameter int ACK_WAIT = 4,
   parameter int TIMEOUT  = 1023
) (
   input  logic             clk,
   input  logic             reset,
   aes_round_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WHITEN, S_TRIG, S_WAIT_ACK, S_WAIT_DONE, S_NEXT, S_OUT
   } state_t;

   localparam int ACK_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT + 1) : 1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [127:0]     r_data;
   logic [127:0]     r_key;
   logic [3:0]       r_round;
   logic             r_err;
   logic             r_busy_q;
   logic [ACK_W-1:0] r_ack_cnt;

   logic w_in_xfer;
   logic w_out_xfer;
   logic w_ack_expired;
   logic w_busy_fall;
   logic w_round_expired;

   assign w_in_xfer     = (r_state == S_IDLE) && bus.in_valid;
   assign w_out_xfer    = (r_state == S_OUT) && bus.out_ready;
   assign w_busy_fall   = r_busy_q && !bus.blk_busy;
   // Down-counter loaded in TRIG; busy is sampled on ACK_WAIT WAIT_ACK cycles.
   assign w_ack_expired = (r_state == S_WAIT_ACK) && !bus.blk_busy && (r_ack_cnt == '0);

`ifdef ROUND_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [TO_W-1:0] r_to_cnt;

   // Reloaded while waiting for the ack so every round starts with a full budget.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_to_cnt <= '0;
      end else if (r_state == S_WAIT_ACK) begin
         r_to_cnt <= TO_W'(TIMEOUT - 1);
      end else if ((r_state == S_WAIT_DONE) && bus.blk_busy && (r_to_cnt != '0)) begin
         r_to_cnt <= r_to_cnt - 1'b1;
      end
   end

   assign w_round_expired = (r_state == S_WAIT_DONE) && bus.blk_busy && (r_to_cnt == '0);
`else
   assign w_round_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (w_in_xfer) w_state_nxt = S_WHITEN;
         S_WHITEN:    w_state_nxt = S_TRIG;
         S_TRIG:      w_state_nxt = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (bus.blk_busy)       w_state_nxt = S_WAIT_DONE;
            else if (w_ack_expired) w_state_nxt = S_IDLE;
         end
         S_WAIT_DONE: begin
            if (w_busy_fall)          w_state_nxt = S_NEXT;
            else if (w_round_expired) w_state_nxt = S_IDLE;
         end
         S_NEXT:      w_state_nxt = (r_round == 4'd10) ? S_OUT : S_TRIG;
         S_OUT:       if (w_out_xfer) w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.blk_trig  = 1'b0;
      bus.blk_first = 1'b0;
      bus.blk_end   = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         S_IDLE:  bus.in_ready = 1'b1;
         S_TRIG, S_WAIT_ACK, S_WAIT_DONE: begin
            bus.blk_trig  = (r_state == S_TRIG);
            bus.blk_first = (r_round == 4'd1);
            bus.blk_end   = (r_round == 4'd10);
         end
         S_OUT:   bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.blk_count   = r_round;
   assign bus.blk_data_in = r_data;
   assign bus.blk_key     = r_key;
   assign bus.out_text    = r_data;
   assign bus.err         = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data    <= '0;
         r_key     <= '0;
         r_round   <= '0;
         r_err     <= 1'b0;
         r_busy_q  <= 1'b0;
         r_ack_cnt <= '0;
      end else begin
         r_busy_q <= bus.blk_busy;
         if (w_in_xfer) begin
            r_data <= bus.in_text;
            r_key  <= bus.in_key;
            r_err  <= 1'b0;
         end
         if (w_ack_expired || w_round_expired) begin
            r_err <= 1'b1;
         end
         case (r_state)
            S_WHITEN: begin
               r_data  <= r_data ^ r_key;
               r_round <= 4'd1;
            end
            S_TRIG:     r_ack_cnt <= ACK_W'(ACK_WAIT - 1);
            S_WAIT_ACK: if (r_ack_cnt != '0) r_ack_cnt <= r_ack_cnt - 1'b1;
            S_NEXT: begin
               r_data <= bus.blk_data_out;
               if (r_round != 4'd10) r_round <= r_round + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
   localparam int ACK_WAIT = 4;
`ifdef ROUND_TIMEOUT_EN
   localparam int TO_P = 15;
`else
   localparam int TO_P = 1023;
`endif
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic reset = 1'b1;
   aes_round_ctrl_if bus ();

   aes_round_ctrl #(.ACK_WAIT(ACK_WAIT), .TIMEOUT(TO_P)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // ---------------- AES-128 behavioural primitives ----------------
   logic [7:0] sbox [256];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] inv;
         inv = 8'h00;
         if (v != 0)
            for (int b = 1; b < 256; b++)
               if (gmul(8'(v), 8'(b)) == 8'h01) inv = 8'(b);
         sbox[v] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [7:0] rcon_of(input int r);
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 1; i < r; i++) rc = xt(rc);
      return rc;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, tmp;
      {w0, w1, w2, w3} = k;
      tmp = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
      w0 ^= tmp; w1 ^= w0; w2 ^= w1; w3 ^= w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input bit last);
      logic [7:0] b [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o ^ rk;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] text, input logic [127:0] key);
      logic [127:0] s, k;
      s = text ^ key; k = key;
      for (int r = 1; r <= 10; r++) begin
         k = next_key(k, rcon_of(r));
         s = aes_round(s, k, r == 10);
      end
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- round-block model (acts at posedge+1) ----------------
   int           m_ack = 1;
   int           m_len = 1;
   bit           m_never = 1'b0;
   bit           m_stuck = 1'b0;
   bit           m_force_busy = 1'b0;
   bit           m_act = 1'b0;
   int           since = 0;
   int           trig_cnt = 0;
   logic [127:0] cur_key = '0;
   logic [127:0] m_rk = '0;
   logic [127:0] m_res = '0;

   initial begin
      bus.blk_busy = 1'b0;
      bus.blk_data_out = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            m_act = 1'b0;
            bus.blk_busy = m_force_busy;
         end else begin
            if (bus.blk_trig) begin
               trig_cnt++;
               chk("blk_count at trig", bus.blk_count, trig_cnt);
               chk("blk_first at trig", bus.blk_first, trig_cnt == 1);
               chk("blk_end at trig", bus.blk_end, trig_cnt == 10);
               chk("blk_key at trig", bus.blk_key, cur_key);
               if (bus.blk_first) m_rk = next_key(bus.blk_key, rcon_of(1));
               else               m_rk = next_key(m_rk, rcon_of(int'(bus.blk_count)));
               m_res = aes_round(bus.blk_data_in, m_rk, bus.blk_end);
               since = 0;
               m_act = 1'b1;
            end else if (m_act) begin
               since++;
            end
            if (bus.blk_first) chk("blk_first outside round 1", trig_cnt, 1);
            if (bus.blk_end)   chk("blk_end outside round 10", trig_cnt, 10);
            bus.blk_busy = m_force_busy ||
                           (m_act && !m_never && since >= m_ack && (m_stuck || since < m_ack + m_len));
            bus.blk_data_out = (m_act && since >= m_ack + m_len) ? m_res : rnd128();
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " in_ready"}, bus.in_ready, 1);
      chk({nm, " blk_trig"}, bus.blk_trig, 0);
      chk({nm, " blk_first"}, bus.blk_first, 0);
      chk({nm, " blk_end"}, bus.blk_end, 0);
      chk({nm, " out_valid"}, bus.out_valid, 0);
      chk({nm, " err"}, bus.err, 0);
      chk({nm, " blk_count"}, bus.blk_count, 0);
      chk({nm, " blk_data_in"}, bus.blk_data_in, 0);
      chk({nm, " blk_key"}, bus.blk_key, 0);
      chk({nm, " out_text"}, bus.out_text, 0);
   endtask

   task automatic wait_out(output int n);
      n = 1;
      while (!bus.out_valid && n < 3000) begin step(); n++; end
   endtask

   task automatic run_job(input string nm, input logic [127:0] text, input logic [127:0] key,
                          input int ack, input int len, input int hold, input logic [127:0] exp);
      int n;
      m_ack = ack; m_len = len; trig_cnt = 0; cur_key = key;
      bus.in_valid = 1'b1; bus.in_text = text; bus.in_key = key;
      step();
      bus.in_valid = 1'b0; bus.in_text = rnd128(); bus.in_key = rnd128();
      chk({nm, " err cleared"}, bus.err, 0);
      chk({nm, " in_ready busy"}, bus.in_ready, 0);
      wait_out(n);
      chk({nm, " latency"}, n, 2 + 10 * (ack + len + 2));
      chk({nm, " out_text"}, bus.out_text, exp);
      chk({nm, " trig pulses"}, trig_cnt, 10);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({nm, " hold out_valid"}, bus.out_valid, 1);
         chk({nm, " hold out_text"}, bus.out_text, exp);
         chk({nm, " hold in_ready"}, bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({nm, " idle in_ready"}, bus.in_ready, 1);
      chk({nm, " idle out_valid"}, bus.out_valid, 0);
      chk({nm, " err"}, bus.err, 0);
   endtask

   task automatic ack_err_seq(input string nm);
      int  n;
      bit  seen_ov;
      trig_cnt = 0; cur_key = FIPS_KEY;
      bus.in_valid = 1'b1; bus.in_text = FIPS_PT; bus.in_key = FIPS_KEY;
      step();
      bus.in_valid = 1'b0;
      chk({nm, " err cleared"}, bus.err, 0);
      n = 0;
      while (!bus.blk_trig && n < 10) begin step(); n++; end
      chk({nm, " trig seen"}, bus.blk_trig, 1);
      repeat (ACK_WAIT) step();
      chk({nm, " err inside window"}, bus.err, 0);
      step();
      chk({nm, " err set"}, bus.err, 1);
      chk({nm, " in_ready"}, bus.in_ready, 1);
      seen_ov = 1'b0;
      repeat (10) begin
         step();
         if (bus.out_valid) seen_ov = 1'b1;
      end
      chk({nm, " out_valid stays 0"}, seen_ov, 0);
      chk({nm, " err sticky"}, bus.err, 1);
      chk({nm, " no retrigger"}, trig_cnt, 1);
   endtask

   typedef struct {
      string        nm;
      logic [127:0] text;
      logic [127:0] key;
      int           ack;
      int           len;
      int           hold;
      logic [127:0] exp;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int            n;
      logic [127:0]  ta, ka, tb, kb;
      bit            seen;
      bus.in_valid = 1'b0; bus.in_text = '0; bus.in_key = '0; bus.out_ready = 1'b0;
      build_sbox();

      ta = rnd128(); ka = rnd128(); tb = rnd128(); kb = rnd128();
      tbl[0] = '{"fips197", FIPS_PT, FIPS_KEY, 1, 1, 20, FIPS_CT};
      tbl[1] = '{"zero", 128'h0, 128'h0, 1, 3, 0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      tbl[2] = '{"ack_at_limit", ta, ka, ACK_WAIT, 2, 1, aes_ref(ta, ka)};
      tbl[3] = '{"ack2", tb, kb, 2, 1, 3, aes_ref(tb, kb)};

      repeat (3) step();
      chk_reset_vals("reset");
      reset = 1'b0;
      step();
      chk_reset_vals("after reset");

      m_force_busy = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         step();
         if (bus.blk_trig || !bus.in_ready) seen = 1'b1;
      end
      chk("busy in idle ignored", seen, 0);
      m_force_busy = 1'b0;
      step(); step();

      for (int i = 0; i < 4; i++)
         run_job(tbl[i].nm, tbl[i].text, tbl[i].key, tbl[i].ack, tbl[i].len, tbl[i].hold, tbl[i].exp);

      m_never = 1'b1;
      ack_err_seq("no_ack");
      m_never = 1'b0;
      m_ack = ACK_WAIT + 1; m_len = 2;
      ack_err_seq("late_ack");
      step(); step(); step();

      ta = rnd128(); ka = rnd128();
      run_job("after_err", ta, ka, 1, 2, 0, aes_ref(ta, ka));

      m_ack = 1; m_len = 2; trig_cnt = 0; cur_key = FIPS_KEY;
      bus.in_valid = 1'b1; bus.in_text = FIPS_PT; bus.in_key = FIPS_KEY;
      step();
      bus.in_valid = 1'b0;
      n = 0;
      while (trig_cnt < 5 && n < 300) begin step(); n++; end
      chk("reached round 5", trig_cnt, 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_reset_vals("mid-job reset");
      trig_cnt = 0;
      repeat (20) step();
      chk("no trig after reset", trig_cnt, 0);
      run_job("fips_after_reset", FIPS_PT, FIPS_KEY, 1, 1, 0, FIPS_CT);

      ta = rnd128(); ka = rnd128(); tb = rnd128(); kb = rnd128();
      m_ack = 1; m_len = 1; trig_cnt = 0; cur_key = ka;
      bus.in_valid = 1'b1; bus.in_text = ta; bus.in_key = ka;
      step();
      bus.in_text = tb; bus.in_key = kb;
      wait_out(n);
      chk("b2b first latency", n, 2 + 10 * 4);
      chk("b2b first out_text", bus.out_text, aes_ref(ta, ka));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("b2b idle in_ready", bus.in_ready, 1);
      trig_cnt = 0; cur_key = kb;
      step();
      bus.in_valid = 1'b0;
      chk("b2b second accepted", bus.in_ready, 0);
      wait_out(n);
      chk("b2b second latency", n, 2 + 10 * 4);
      chk("b2b second out_text", bus.out_text, aes_ref(tb, kb));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;

      for (int j = 0; j < 4; j++) begin
         ta = rnd128(); ka = rnd128();
         run_job("random", ta, ka, int'($urandom_range(ACK_WAIT, 1)), int'($urandom_range(4, 1)),
                 int'($urandom_range(3, 0)), aes_ref(ta, ka));
      end

`ifdef ROUND_TIMEOUT_EN
      m_ack = 1; m_stuck = 1'b1; trig_cnt = 0; cur_key = FIPS_KEY;
      bus.in_valid = 1'b1; bus.in_text = FIPS_PT; bus.in_key = FIPS_KEY;
      step();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.blk_trig && n < 10) begin step(); n++; end
      chk("timeout trig seen", bus.blk_trig, 1);
      n = 0;
      while (!bus.err && n < 100) begin step(); n++; end
      chk("timeout err cycle", n, TO_P + 2);
      chk("timeout in_ready", bus.in_ready, 1);
      chk("timeout out_valid", bus.out_valid, 0);
      m_stuck = 1'b0;
      step(); step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end of test, expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
